// File: rtl/gpio_bank_if.sv
// CPU IO bus as seen by a GPIO bank: one select, a register index, strobes and data.
// The CPU side drives the master modport; the bank is the slave and returns read data.
interface gpio_bank_if;
  logic        io_sel;
  logic [3:0]  io_reg;
  logic        io_write_enable;
  logic        io_read_enable;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;

  modport master (
    output io_sel, io_reg, io_write_enable, io_read_enable, io_write_data,
    input  io_read_data
  );

  modport slave (
    input  io_sel, io_reg, io_write_enable, io_read_enable, io_write_data,
    output io_read_data
  );
endinterface

// File: rtl/gpio_bank.sv
// Bank of NPORTS GPIO ports: output latch, direction, 2-flop input synchroniser and sticky
// edge flags per bit, with one shared level interrupt. Pad primitives live in the board top.
module gpio_bank #(
  parameter int NPORTS = 2,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  gpio_bank_if.slave              bus,
  input  logic [NPORTS*WIDTH-1:0] pad_in,
  output logic [NPORTS*WIDTH-1:0] pad_out,
  output logic [NPORTS*WIDTH-1:0] pad_oe,
  output logic                    irq
);

  localparam int N = NPORTS * WIDTH;

  logic [N-1:0] latch_q, latch_d;
  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] flag_q, flag_d;
  logic [N-1:0] riseEn_q, riseEn_d;
  logic [N-1:0] fallEn_q, fallEn_d;
  logic [N-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]   armCnt_q;
  logic         irq_q;

  logic [1:0]   portIdx;
  logic [1:0]   regIdx;
  logic         portValid;
  logic         wrEn;
  int           base;
  logic [N-1:0] clrBits;
  logic [N-1:0] setBits;
  logic [15:0]  readData;
  logic         unusedBits;

  assign portIdx    = bus.io_reg[3:2];
  assign regIdx     = bus.io_reg[1:0];
  assign portValid  = int'(portIdx) < NPORTS;
  assign base       = int'(portIdx) * WIDTH;
  assign wrEn       = bus.io_sel & bus.io_write_enable & portValid;
  assign unusedBits = &{1'b0, bus.io_read_enable, bus.io_write_data};

  always_comb begin
    latch_d  = latch_q;
    dir_d    = dir_q;
    riseEn_d = riseEn_q;
    fallEn_d = fallEn_q;
    clrBits  = '0;
    if (wrEn) begin
      case (regIdx)
        2'd0: latch_d[base +: WIDTH] = bus.io_write_data[WIDTH-1:0];
        2'd1: dir_d[base +: WIDTH]   = bus.io_write_data[WIDTH-1:0];
        2'd2: clrBits[base +: WIDTH] = bus.io_write_data[WIDTH-1:0];
        2'd3: begin
          riseEn_d[base +: WIDTH] = bus.io_write_data[WIDTH-1:0];
          fallEn_d[base +: WIDTH] = bus.io_write_data[8 +: WIDTH];
        end
      endcase
    end
    // Edges are ignored until the synchroniser has flushed its reset zeros; set beats clear.
    setBits = (armCnt_q == 2'd3)
            ? ((sync2_q & ~prev_q & riseEn_q) | (~sync2_q & prev_q & fallEn_q))
            : '0;
    flag_d  = (flag_q & ~clrBits) | setBits;
  end

  always_comb begin
    readData = '0;
    if (bus.io_sel && portValid) begin
      case (regIdx)
        2'd0: readData[WIDTH-1:0] = sync2_q[base +: WIDTH];
        2'd1: readData[WIDTH-1:0] = dir_q[base +: WIDTH];
        2'd2: readData[WIDTH-1:0] = flag_q[base +: WIDTH];
        2'd3: begin
          readData[WIDTH-1:0] = riseEn_q[base +: WIDTH];
          readData[8 +: WIDTH] = fallEn_q[base +: WIDTH];
        end
      endcase
    end
  end

  assign bus.io_read_data = readData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q  <= '0;
      dir_q    <= '0;
      flag_q   <= '0;
      riseEn_q <= '0;
      fallEn_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      armCnt_q <= 2'd0;
      irq_q    <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      dir_q    <= dir_d;
      flag_q   <= flag_d;
      riseEn_q <= riseEn_d;
      fallEn_q <= fallEn_d;
      sync1_q  <= pad_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      if (armCnt_q != 2'd3) begin
        armCnt_q <= armCnt_q + 2'd1;
      end
      irq_q    <= |flag_q;
    end
  end

  assign pad_out = latch_q;
  assign pad_oe  = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed scenarios plus random bus/pad traffic, with read data checked
// through a scoreboard queue against a pad-history reference model.
module tb_gpio_bank;
  localparam int NPORTS = 2;
  localparam int WIDTH  = 8;
  localparam int N      = NPORTS * WIDTH;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] padIn = '1;
  logic [N-1:0] padOut;
  logic [N-1:0] padOe;
  logic         irq;
  logic [N-1:0] padCur = '1;

  gpio_bank_if bus ();

  gpio_bank #(.NPORTS(NPORTS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pad_in  (padIn),
    .pad_out (padOut),
    .pad_oe  (padOe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } expItem_t;

  expItem_t expQ[$];
  int errors = 0;
  int checks = 0;

  // Reference state: registers as the bus sees them, plus every pad sample since reset release.
  logic [N-1:0] mLatch = '0;
  logic [N-1:0] mDir   = '0;
  logic [N-1:0] mFlag  = '0;
  logic [N-1:0] mRise  = '0;
  logic [N-1:0] mFall  = '0;
  logic         mIrq   = 1'b0;
  logic [N-1:0] padHist[$];
  int           edgeCount = 0;

  function automatic logic [N-1:0] histAt(int i);
    if (i < 1) return '0;
    return padHist[i-1];
  endfunction

  // After edge n the input reads pad sample n-1; an edge between samples n-3 and n-2 flags at edge n.
  always @(posedge clk or posedge reset) begin : model
    logic [N-1:0] rise, fall, setv, clr, older, newer;
    int p, r;
    if (reset) begin
      mLatch = '0; mDir = '0; mFlag = '0; mRise = '0; mFall = '0; mIrq = 1'b0;
      padHist.delete();
      edgeCount = 0;
    end else begin
      edgeCount++;
      padHist.push_back(padIn);
      newer = histAt(edgeCount - 2);
      older = histAt(edgeCount - 3);
      rise  = newer & ~older;
      fall  = ~newer & older;
      setv  = (edgeCount >= 4) ? ((rise & mRise) | (fall & mFall)) : '0;
      mIrq  = (mFlag != '0);
      clr   = '0;
      p = int'(bus.io_reg[3:2]);
      r = int'(bus.io_reg[1:0]);
      if (bus.io_sel && bus.io_write_enable && p < NPORTS) begin
        case (r)
          0: mLatch[p*WIDTH +: WIDTH] = bus.io_write_data[WIDTH-1:0];
          1: mDir[p*WIDTH +: WIDTH]   = bus.io_write_data[WIDTH-1:0];
          2: clr[p*WIDTH +: WIDTH]    = bus.io_write_data[WIDTH-1:0];
          default: begin
            mRise[p*WIDTH +: WIDTH] = bus.io_write_data[WIDTH-1:0];
            mFall[p*WIDTH +: WIDTH] = bus.io_write_data[8 +: WIDTH];
          end
        endcase
      end
      mFlag = (mFlag & ~clr) | setv;
    end
  end

  function automatic logic [15:0] modelRead(logic sel, logic [3:0] rg);
    logic [15:0]  v;
    logic [N-1:0] synced;
    int p;
    v = '0;
    p = int'(rg[3:2]);
    if (!sel || p >= NPORTS) return '0;
    synced = histAt(edgeCount - 1);
    case (rg[1:0])
      2'd0: v[WIDTH-1:0] = synced[p*WIDTH +: WIDTH];
      2'd1: v[WIDTH-1:0] = mDir[p*WIDTH +: WIDTH];
      2'd2: v[WIDTH-1:0] = mFlag[p*WIDTH +: WIDTH];
      default: begin
        v[WIDTH-1:0] = mRise[p*WIDTH +: WIDTH];
        v[8 +: WIDTH] = mFall[p*WIDTH +: WIDTH];
      end
    endcase
    return v;
  endfunction

  // Drives one bus cycle just after a rising edge; a read queues its expected data.
  task automatic applyStimulus(input string nm, input logic sel, input logic we, input logic re,
                               input logic [3:0] rg, input logic [15:0] wd,
                               input logic [N-1:0] pad, input int expOv);
    expItem_t item;
    @(posedge clk);
    #1;
    bus.io_sel          = sel;
    bus.io_write_enable = we;
    bus.io_read_enable  = re;
    bus.io_reg          = rg;
    bus.io_write_data   = wd;
    padIn               = pad;
    padCur              = pad;
    if (re) begin
      item.name = nm;
      item.exp  = (expOv < 0) ? modelRead(sel, rg) : 16'(expOv);
      expQ.push_back(item);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus("idle", 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, padCur, -1);
    end
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever a read strobe is presented, and tracks the pins each cycle.
  always @(negedge clk) begin : monitor
    expItem_t item;
    if (bus.io_read_enable) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected read: got %h with no expectation queued", bus.io_read_data);
      end else begin
        item = expQ.pop_front();
        checkOutput(item.name, 32'(bus.io_read_data), 32'(item.exp));
      end
    end
    checkOutput("pad_out", 32'(padOut), 32'(mLatch));
    checkOutput("pad_oe", 32'(padOe), 32'(mDir));
    checkOutput("irq", 32'(irq), 32'(mIrq));
  end

  initial begin
    bus.io_sel = 1'b0; bus.io_write_enable = 1'b0; bus.io_read_enable = 1'b0;
    bus.io_reg = 4'h0; bus.io_write_data = 16'h0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // Release with all pads high: input shows up, but the arm window keeps the flags clear.
    applyStimulus("cfg0 pre", 1, 1, 1, 4'h3, 16'h00FF, 16'hFFFF, 16'h0000);
    applyStimulus("data0 sync", 1, 0, 1, 4'h0, 16'h0, 16'hFFFF, 16'h00FF);
    applyStimulus("flag0 arm a", 1, 0, 1, 4'h2, 16'h0, 16'hFFFF, 16'h0000);
    applyStimulus("flag0 arm b", 1, 0, 1, 4'h2, 16'h0, 16'hFFFF, 16'h0000);
    applyStimulus("cfg0 read", 1, 0, 1, 4'h3, 16'h0, 16'hFFFF, 16'h00FF);
    checkOutput("irq after arm", 32'(irq), 32'h0);

    // Direction and output latch are independent of the sampled input.
    applyStimulus("dir0 pre", 1, 1, 1, 4'h1, 16'h00F0, 16'hFFFF, 16'h0000);
    applyStimulus("data0 in", 1, 1, 1, 4'h0, 16'h00A5, 16'hFFFF, 16'h00FF);
    applyStimulus("dir0 read", 1, 0, 1, 4'h1, 16'h0, 16'hFFFF, 16'h00F0);
    checkOutput("pad_oe F0", 32'(padOe), 32'h00F0);
    checkOutput("pad_out A5", 32'(padOut), 32'h00A5);

    // Single rising edge on pad 8 with only that bit enabled.
    applyStimulus("cfg1 pre", 1, 1, 1, 4'h7, 16'h0001, 16'h00FF, 16'h0000);
    idle(3);
    applyStimulus("flag1 k", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0000);
    applyStimulus("flag1 k+1", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0000);
    applyStimulus("flag1 k+2 pre", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0000);
    applyStimulus("flag1 set", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0001);
    checkOutput("irq k+2", 32'(irq), 32'h0);
    applyStimulus("flag1 w1c pre", 1, 1, 1, 4'h6, 16'h0001, 16'h01FF, 16'h0001);
    checkOutput("irq k+3", 32'(irq), 32'h1);
    applyStimulus("flag1 cleared", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0000);
    checkOutput("irq lag", 32'(irq), 32'h1);
    applyStimulus("flag1 idle", 1, 0, 1, 4'h6, 16'h0, 16'h01FF, 16'h0000);
    checkOutput("irq low", 32'(irq), 32'h0);

    // Falls on all of port 0, then a fresh rise on bit 0 colliding with a W1C of every bit.
    applyStimulus("cfg0 both pre", 1, 1, 1, 4'h3, 16'hFFFF, 16'h01FF, 16'h00FF);
    applyStimulus("fall pad", 0, 0, 0, 4'h0, 16'h0, 16'h0100, -1);
    idle(3);
    applyStimulus("flag0 falls", 1, 0, 1, 4'h2, 16'h0, 16'h0100, 16'h00FF);
    applyStimulus("rise pad", 0, 0, 0, 4'h0, 16'h0, 16'h0101, -1);
    idle(1);
    applyStimulus("flag0 collide", 1, 1, 1, 4'h2, 16'h00FF, 16'h0101, 16'h00FF);
    applyStimulus("flag0 set wins", 1, 0, 1, 4'h2, 16'h0, 16'h0101, 16'h0001);
    applyStimulus("flag0 clr bit0", 1, 1, 1, 4'h2, 16'h0001, 16'h0101, 16'h0001);
    applyStimulus("flag0 empty", 1, 0, 1, 4'h2, 16'h0, 16'h0101, 16'h0000);

    // Out-of-range port and deselected bank.
    applyStimulus("port2 data", 1, 1, 1, 4'h8, 16'hFFFF, 16'h0101, 16'h0000);
    applyStimulus("port2 cfg", 1, 1, 1, 4'hB, 16'hFFFF, 16'h0101, 16'h0000);
    applyStimulus("unselected", 0, 1, 1, 4'h1, 16'h000F, 16'h0101, 16'h0000);
    applyStimulus("dir0 kept", 1, 0, 1, 4'h1, 16'h0, 16'h0101, 16'h00F0);
    applyStimulus("cfg0 kept", 1, 0, 1, 4'h3, 16'h0, 16'h0101, 16'hFFFF);
    applyStimulus("data0 kept", 1, 0, 1, 4'h0, 16'h0, 16'h0101, 16'h0001);
    checkOutput("pad_out kept", 32'(padOut), 32'h00A5);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] pad;
      pad = padCur ^ N'($urandom & $urandom & $urandom);
      applyStimulus("random", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'b1,
                    4'($urandom_range(0, 15)), 16'($urandom), pad, -1);
    end

    // Raise irq, then reset asynchronously between clock edges.
    applyStimulus("cfg0 final", 1, 1, 0, 4'h3, 16'hFFFF, padCur, -1);
    applyStimulus("toggle0", 0, 0, 0, 4'h0, 16'h0, padCur ^ 16'h00FF, -1);
    idle(4);
    applyStimulus("dir0 ff", 1, 1, 0, 4'h1, 16'h00FF, padCur, -1);
    idle(1);
    checkOutput("irq before reset", 32'(irq), 32'h1);
    checkOutput("pad_oe0 before reset", 32'(padOe[7:0]), 32'h00FF);
    bus.io_sel = 1'b1; bus.io_write_enable = 1'b0; bus.io_read_enable = 1'b0; bus.io_reg = 4'h2;
    #2 reset = 1'b1;
    #1;
    checkOutput("irq async reset", 32'(irq), 32'h0);
    checkOutput("pad_oe async reset", 32'(padOe), 32'h0);
    checkOutput("pad_out async reset", 32'(padOut), 32'h0);
    checkOutput("flag0 async reset", 32'(bus.io_read_data), 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    applyStimulus("dir0 after reset", 1, 0, 1, 4'h1, 16'h0, padCur, 16'h0000);
    applyStimulus("flag0 after reset", 1, 0, 1, 4'h2, 16'h0, padCur, 16'h0000);
    idle(3);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
